// File: rtl/dmem_if.sv
// Valid/ready request and response channels between the core's data-memory port
// (master) and the data-memory responder (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM behind a valid/ready request/response port, with
// programmable wait states, byte-enable stores and misaligned/out-of-range flagging.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic [31:0]   acc_off;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic          do_access;
    logic          mem_we;

    assign bus.req_ready = (state_q == IDLE) && reset;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    // With zero wait states the access happens at the accept edge, so it must use
    // the live request fields rather than the not-yet-latched copies.
    always_comb begin
        if (state_q == IDLE) begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_be    = bus.req_be;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
        acc_off = acc_addr - BASE_ADDR;
        acc_err = (acc_addr[1:0] != 2'b00) || (acc_off >= SPAN);
        acc_idx = acc_off[AW+1:2];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        do_access = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    if (WAIT_STATES == 0) begin
                        do_access = 1'b1;
                        state_d   = RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    do_access = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_access) begin
            err_d   = acc_err;
            rdata_d = (acc_we || acc_err) ? 32'h0 : mem_q[acc_idx];
        end
        mem_we = do_access && acc_we && !acc_err;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM contents survive reset; a store caught by reset is simply never written.
    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
